thread_fetch_unit: RTL and testbench
====================================

Name: thread_fetch_unit

Overview:
- Multithreaded fetch stage directly upstream of the instruction cache.
- Holds one PC per hardware thread and picks one eligible thread per cycle, round-robin.
- Drives the cache read port (Enable, 7-bit word index), then presents the returned instruction to decode over a valid/ready handshake, tagged with thread id and PC.
- Accepts per-thread redirects from execute, squashing any stale in-flight fetch.

Parameters:
- NUM_THREADS, 4, number of hardware threads (power of 2, 2..8).
- RESET_PC, 32'h0000_0000, byte PC of thread 0 after reset.
- THREAD_STRIDE, 32'h0000_0080, reset PC offset between consecutive threads (thread t starts at RESET_PC + t*THREAD_STRIDE).

Ports:
- clk  in  1  clock, all state on rising edge.
- Reset  in  1  synchronous, active-high reset.
- ThreadActive  in  NUM_THREADS  per-thread run enable.
- ThreadHold  in  NUM_THREADS  per-thread stall from downstream (hazard/branch pending).
- Redirect  in  1  redirect request valid.
- RedirectThread  in  $clog2(NUM_THREADS)  thread being redirected.
- RedirectPC  in  32  new byte PC (bits [1:0] ignored, treated as 0).
- CacheEnable  out  1  read enable to instruction cache.
- CacheIndexRead  out  7  word index = selected PC[8:2].
- CacheInst  in  32  cache read data, registered inside cache, valid 1 cycle after CacheEnable.
- FetchValid  out  1  instruction available to decode.
- DecodeReady  in  1  decode accepts this cycle.
- FetchInst  out  32  instruction (= CacheInst, passed through).
- FetchPC  out  32  byte PC of FetchInst.
- FetchThread  out  $clog2(NUM_THREADS)  thread id of FetchInst.

Behaviour:
- Reset, while high:
  - PC[t] <= RESET_PC + t*THREAD_STRIDE.
  - RR pointer <= 0.
  - out_valid <= 0; FetchPC <= 0; FetchThread <= 0.
  - CacheEnable forced 0.
  - Reset mid-fetch discards the in-flight slot with no handshake.
- Advance = !out_valid || DecodeReady || squash.
- Eligible[t] = ThreadActive[t] && !ThreadHold[t] && !(Redirect && RedirectThread==t).
- Selection:
  - On advance, pick the first eligible thread scanning from RR pointer upward, modulo NUM_THREADS.
  - RR pointer <= selected+1 (wraps to 0 after NUM_THREADS-1).
  - With no eligible thread, the pointer is unchanged.
- Issue cycle T (advance && some eligible t):
  - CacheEnable=1, CacheIndexRead=PC[t][8:2].
  - out_valid<=1, out_tid<=t, out_pc<=PC[t].
  - PC[t] <= PC[t]+4, modulo 2^32 (FFFF_FFFC wraps to 0).
  - PC bits above [8] do not affect the index; addresses alias within 128 words.
- Cycle T+1: FetchValid=out_valid && !squash, FetchInst=CacheInst. Latency select→FetchValid = 1 cycle.
- Advance with no eligible thread: CacheEnable=0, out_valid<=0 (bubble).
- Stall (out_valid && !DecodeReady && !squash):
  - CacheEnable=0, so the cache holds Inst.
  - FetchInst/FetchPC/FetchThread stable.
  - No PC changes except redirects.
- Redirect:
  - PC[RedirectThread] <= {RedirectPC[31:2],2'b00} next edge; this overrides any same-cycle increment.
  - squash = Redirect && out_valid && out_tid==RedirectThread. Squash forces FetchValid=0 that cycle and frees the slot (advance=1).
  - The redirected thread is ineligible that cycle; its first post-redirect fetch issues at the earliest in the following cycle.
- ThreadActive deassert: thread skipped from the next selection. An already-issued fetch completes normally.
- Throughput: 1 instruction/cycle when DecodeReady held high and at least one thread eligible.

Decomposition:
- Shared package fetch_pkg holds:
  - THREAD_ID_W.
  - ICACHE_INDEX_W=7 and the index slice bounds [8:2].
  - PC_INC=4.
  - typedef fetch_slot_t {valid, tid, pc}.
- One natural sub-module: rr_arbiter (NUM_THREADS request vector + pointer → grant index, any_grant).

Test Plan:
- Reset, all 4 threads active, DecodeReady=1 → CacheIndexRead sequence 0x00,0x20,0x40,0x60,0x01,0x21; FetchThread 0,1,2,3,0,1; FetchPC 0x0,0x80,0x100,0x180,0x4 starting one cycle after first CacheEnable.
- Preload cache word 0x21=32'hDEADBEEF, thread1 only active → FetchInst=DEADBEEF with FetchPC=0x84 on second fetch.
- DecodeReady low 3 cycles while FetchValid=1 → CacheEnable=0, outputs stable for 3 cycles, no PC advance, next instruction follows exactly once.
- Redirect thread2 to 0x1F4 while out_tid=2 valid → FetchValid=0 that cycle; thread2 not selected that cycle; next thread2 fetch index 0x7D, FetchPC=0x1F4.
- ThreadHold=4'b1011, ThreadActive=4'b1111 → only thread2 fetched every cycle; all held → CacheEnable=0, FetchValid=0 bubbles, RR pointer unchanged.
- Redirect thread0 to 0xFFFF_FFFC → index 0x7F, next thread0 FetchPC=0x0000_0000 (wrap); Reset asserted mid-stall → FetchValid=0 next cycle, PCs back to 0x0/0x80/0x100/0x180.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the thread fetch unit
package fetch_pkg;

    // Widest thread id the unit supports; narrower configurations zero-extend.
    localparam int MAX_THREADS    = 8;
    localparam int THREAD_ID_W    = $clog2(MAX_THREADS);

    // Instruction cache read port: 128 words, indexed by byte PC bits [8:2].
    localparam int ICACHE_INDEX_W = 7;
    localparam int INDEX_LSB      = 2;
    localparam int INDEX_MSB      = INDEX_LSB + ICACHE_INDEX_W - 1;

    localparam logic [31:0] PC_INC = 32'd4;

    // The one in-flight fetch between the cache read and decode.
    typedef struct packed {
        logic                   valid;
        logic [THREAD_ID_W-1:0] tid;
        logic [31:0]            pc;
    } fetch_slot_t;

    // Redirect targets are word aligned; the low two bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'd3;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin request picker starting from a pointer
module rr_arbiter #(
    parameter int  N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] grant,
    output logic         any_grant
);

    logic [W-1:0] idx;

    // Scan upward from ptr, wrapping naturally in W bits, and take the first requester.
    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        idx       = '0;
        for (int i = 0; i < N; i++) begin
            idx = ptr + W'(i);
            if (!any_grant && req[idx]) begin
                grant     = idx;
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/thread_fetch_unit.sv
// rtl/thread_fetch_unit.sv - multithreaded round-robin instruction fetch stage
module thread_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          NUM_THREADS   = 4,
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter logic [31:0] THREAD_STRIDE = 32'h0000_0080,
    localparam int         TID_W         = $clog2(NUM_THREADS)
) (
    input  logic                      clk,
    input  logic                      Reset,
    input  logic [NUM_THREADS-1:0]    ThreadActive,
    input  logic [NUM_THREADS-1:0]    ThreadHold,
    input  logic                      Redirect,
    input  logic [TID_W-1:0]          RedirectThread,
    input  logic [31:0]               RedirectPC,
    output logic                      CacheEnable,
    output logic [ICACHE_INDEX_W-1:0] CacheIndexRead,
    input  logic [31:0]               CacheInst,
    output logic                      FetchValid,
    input  logic                      DecodeReady,
    output logic [31:0]               FetchInst,
    output logic [31:0]               FetchPC,
    output logic [TID_W-1:0]          FetchThread
);

    logic [31:0]            pc_q [NUM_THREADS];
    logic [TID_W-1:0]       rr_ptr_q;
    fetch_slot_t            slot_q;

    logic [NUM_THREADS-1:0] eligible;
    logic [TID_W-1:0]       grant;
    logic                   any_grant;
    logic                   squash;
    logic                   advance;
    logic                   issue;

    // A redirect for the thread sitting in the output slot makes that instruction stale.
    always_comb begin
        squash  = Redirect && slot_q.valid && (slot_q.tid == THREAD_ID_W'(RedirectThread));
        advance = !slot_q.valid || DecodeReady || squash;
    end

    // A thread being redirected this cycle must not fetch from its old PC.
    always_comb begin
        eligible = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            eligible[t] = ThreadActive[t] && !ThreadHold[t]
                          && !(Redirect && (RedirectThread == TID_W'(t)));
        end
    end

    rr_arbiter #(
        .N (NUM_THREADS)
    ) u_rr_arbiter (
        .req       (eligible),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .any_grant (any_grant)
    );

    // Cache read port and decode-facing outputs; the cache register holds data while disabled.
    always_comb begin
        issue          = advance && any_grant && !Reset;
        CacheEnable    = issue;
        CacheIndexRead = pc_q[grant][INDEX_MSB:INDEX_LSB];
        FetchValid     = slot_q.valid && !squash;
        FetchInst      = CacheInst;
        FetchPC        = slot_q.pc;
        FetchThread    = TID_W'(slot_q.tid);
    end

    // Per-thread PCs, round-robin pointer and the output slot.
    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                pc_q[t] <= RESET_PC + (32'(t) * THREAD_STRIDE);
            end
            rr_ptr_q <= '0;
            slot_q   <= '0;
        end else begin
            if (issue) begin
                pc_q[grant] <= pc_q[grant] + PC_INC;
            end
            // Later assignment wins, so a redirect overrides a same-cycle increment.
            if (Redirect) begin
                pc_q[RedirectThread] <= align_pc(RedirectPC);
            end
            if (advance) begin
                slot_q.valid <= any_grant;
                if (any_grant) begin
                    slot_q.tid <= THREAD_ID_W'(grant);
                    slot_q.pc  <= pc_q[grant];
                    rr_ptr_q   <= grant + TID_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_thread_fetch_unit.sv
// tb/tb_thread_fetch_unit.sv - randomized self-checking bench for thread_fetch_unit
module tb_thread_fetch_unit;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        Reset;
    logic [N-1:0] ThreadActive;
    logic [N-1:0] ThreadHold;
    logic        Redirect;
    logic [1:0]  RedirectThread;
    logic [31:0] RedirectPC;
    logic        CacheEnable;
    logic [6:0]  CacheIndexRead;
    logic [31:0] CacheInst = 32'h0;
    logic        FetchValid;
    logic        DecodeReady;
    logic [31:0] FetchInst;
    logic [31:0] FetchPC;
    logic [1:0]  FetchThread;

    thread_fetch_unit #(
        .NUM_THREADS   (N),
        .RESET_PC      (32'h0000_0000),
        .THREAD_STRIDE (32'h0000_0080)
    ) dut (
        .clk            (clk),
        .Reset          (Reset),
        .ThreadActive   (ThreadActive),
        .ThreadHold     (ThreadHold),
        .Redirect       (Redirect),
        .RedirectThread (RedirectThread),
        .RedirectPC     (RedirectPC),
        .CacheEnable    (CacheEnable),
        .CacheIndexRead (CacheIndexRead),
        .CacheInst      (CacheInst),
        .FetchValid     (FetchValid),
        .DecodeReady    (DecodeReady),
        .FetchInst      (FetchInst),
        .FetchPC        (FetchPC),
        .FetchThread    (FetchThread)
    );

    always #5 clk = ~clk;

    // Instruction cache: registered read, holds its output when not enabled.
    logic [31:0] mem [128];
    always @(posedge clk) begin
        if (CacheEnable) CacheInst <= mem[CacheIndexRead];
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: one PC per thread, a next-to-try pointer, and the instruction owed to decode.
    logic [31:0] m_pc [N];
    int          m_rr;
    bit          m_valid;
    int          m_tid;
    logic [31:0] m_opc;
    logic [31:0] m_inst;

    logic        obs_ce, obs_fv;
    logic [6:0]  obs_idx;
    logic [31:0] obs_pc, obs_inst;
    logic [1:0]  obs_tid;

    // Inputs are already set just after a falling edge; check, advance the model, then cross the rising edge.
    task automatic cycle();
        bit   sq, adv, found;
        int   g, t;
        #2;
        obs_ce   = CacheEnable;
        obs_idx  = CacheIndexRead;
        obs_fv   = FetchValid;
        obs_pc   = FetchPC;
        obs_tid  = FetchThread;
        obs_inst = FetchInst;
        if (Reset) begin
            check_eq("ce_in_reset", 32'(CacheEnable), 32'd0);
            for (int k = 0; k < N; k++) m_pc[k] = 32'h80 * k;
            m_rr    = 0;
            m_valid = 0;
            m_tid   = 0;
            m_opc   = 0;
        end else begin
            sq  = Redirect && m_valid && (m_tid == int'(RedirectThread));
            adv = !m_valid || DecodeReady || sq;
            check_eq("fetch_valid", 32'(FetchValid), 32'(m_valid && !sq));
            if (m_valid && !sq) begin
                check_eq("fetch_inst", FetchInst, m_inst);
                check_eq("fetch_pc", FetchPC, m_opc);
                check_eq("fetch_thread", 32'(FetchThread), 32'(m_tid));
            end
            found = 0;
            g     = 0;
            for (int k = 0; k < N; k++) begin
                t = (m_rr + k) % N;
                if (!found && ThreadActive[t] && !ThreadHold[t]
                    && !(Redirect && int'(RedirectThread) == t)) begin
                    found = 1;
                    g     = t;
                end
            end
            check_eq("cache_enable", 32'(CacheEnable), 32'(adv && found));
            if (adv && found) begin
                check_eq("cache_index", 32'(CacheIndexRead), 32'((m_pc[g] / 4) % 128));
            end
            if (adv) begin
                m_valid = found;
                if (found) begin
                    m_tid   = g;
                    m_opc   = m_pc[g];
                    m_inst  = mem[(m_pc[g] / 4) % 128];
                    m_pc[g] = m_pc[g] + 32'd4;
                    m_rr    = (g + 1) % N;
                end
            end
            if (Redirect) m_pc[RedirectThread] = {RedirectPC[31:2], 2'b00};
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        Reset    = 1'b1;
        Redirect = 1'b0;
        cycle();
        cycle();
        check_eq("rst_fetch_valid", 32'(FetchValid), 32'd0);
        check_eq("rst_fetch_pc", FetchPC, 32'd0);
        check_eq("rst_fetch_thread", 32'(FetchThread), 32'd0);
        Reset = 1'b0;
    endtask

    logic [6:0]  exp_idx [6];
    logic [31:0] exp_pc  [5];
    bit          hit;

    initial begin
        exp_idx = '{7'h00, 7'h20, 7'h40, 7'h60, 7'h01, 7'h21};
        exp_pc  = '{32'h0, 32'h80, 32'h100, 32'h180, 32'h4};
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        mem[7'h21] = 32'hDEADBEEF;

        Reset          = 1'b1;
        ThreadActive   = '1;
        ThreadHold     = '0;
        Redirect       = 1'b0;
        RedirectThread = '0;
        RedirectPC     = '0;
        DecodeReady    = 1'b1;
        @(negedge clk);

        // All threads active, decode always ready: strict rotation.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle();
            check_eq("rot_ce", 32'(obs_ce), 32'd1);
            check_eq("rot_index", 32'(obs_idx), 32'(exp_idx[i]));
            if (i >= 1) begin
                check_eq("rot_thread", 32'(obs_tid), 32'((i - 1) % N));
                check_eq("rot_pc", obs_pc, exp_pc[i-1]);
            end
        end

        // Thread 1 alone: its second fetch reads the preloaded word 0x21.
        ThreadActive = 4'b0010;
        do_reset();
        cycle();
        cycle();
        cycle();
        check_eq("t1_second_pc", obs_pc, 32'h84);
        check_eq("t1_second_inst", obs_inst, 32'hDEADBEEF);

        // Decode stall for three cycles.
        ThreadActive = '1;
        for (int i = 0; i < 3; i++) cycle();
        DecodeReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("stall_ce", 32'(obs_ce), 32'd0);
        end
        DecodeReady = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        // Redirect thread 2 while its instruction sits in the output slot.
        hit = 0;
        for (int i = 0; i < 8 && !hit; i++) begin
            if (m_valid && m_tid == 2) begin
                Redirect       = 1'b1;
                RedirectThread = 2'd2;
                RedirectPC     = 32'h0000_01F4;
                cycle();
                check_eq("squash_valid", 32'(obs_fv), 32'd0);
                Redirect = 1'b0;
                hit      = 1;
            end else begin
                cycle();
            end
        end
        check_eq("squash_reached", 32'(hit), 32'd1);
        for (int i = 0; i < 8; i++) cycle();

        // Holds: only thread 2 runs, then everything held.
        ThreadHold = 4'b1011;
        for (int i = 0; i < 5; i++) cycle();
        ThreadHold = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check_eq("all_held_ce", 32'(obs_ce), 32'd0);
        end
        ThreadHold = 4'b0000;
        for (int i = 0; i < 5; i++) cycle();

        // Thread 0 to the top of the address space, then reset during a stall.
        Redirect       = 1'b1;
        RedirectThread = 2'd0;
        RedirectPC     = 32'hFFFF_FFFE;
        cycle();
        Redirect = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        DecodeReady = 1'b0;
        cycle();
        cycle();
        do_reset();
        DecodeReady = 1'b1;
        for (int i = 0; i < 6; i++) cycle();

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            Reset          = ($urandom_range(0, 199) == 0);
            ThreadActive   = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom | $urandom);
            ThreadHold     = 4'($urandom & $urandom & $urandom);
            Redirect       = ($urandom_range(0, 5) == 0);
            RedirectThread = 2'($urandom);
            RedirectPC     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))
                                                         : $urandom;
            DecodeReady    = ($urandom_range(0, 9) < 7);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
